// File: rtl/seg_pipe_stage.sv
// Generic inter-stage pipeline register with valid/ready handshake, an optional skid entry
// that fully registers in_ready, synchronous flush, and a saturating flush-drop counter.
module seg_pipe_stage #(
    parameter int unsigned         DATA_W    = 32,
    parameter logic [DATA_W-1:0]   NOP_VALUE = {DATA_W{1'b0}},
    parameter bit                  SKID_EN   = 1'b1,
    parameter int unsigned         CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_commit_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_commit_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  flush_drop_cnt_o
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              main_commit_q, main_commit_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              skid_commit_q, skid_commit_d;
    logic [1:0]        occ_q, occ_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic push, pop;

    // With the skid entry present, in_ready depends only on registered state and en.
    always_comb begin
        if (SKID_EN) begin
            in_ready_o = en_i & ~skid_valid_q;
        end else begin
            in_ready_o = en_i & (~main_valid_q | out_ready_i);
        end
    end

    assign out_valid_o      = en_i & main_valid_q;
    assign out_data_o       = out_valid_o ? main_data_q : NOP_VALUE;
    assign out_commit_o     = main_commit_q & out_valid_o;
    assign occupancy_o      = occ_q;
    assign flush_drop_cnt_o = cnt_q;

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        main_valid_d  = main_valid_q;
        main_data_d   = main_data_q;
        main_commit_d = main_commit_q;
        skid_valid_d  = skid_valid_q;
        skid_data_d   = skid_data_q;
        skid_commit_d = skid_commit_q;
        cnt_d         = cnt_q;

        if (en_i) begin
            if (flush_i) begin
                // Flush wins over any push/pop this cycle; those beats are dropped.
                main_valid_d  = 1'b0;
                main_data_d   = NOP_VALUE;
                main_commit_d = 1'b0;
                skid_valid_d  = 1'b0;
                skid_data_d   = NOP_VALUE;
                skid_commit_d = 1'b0;
                if ((main_valid_q | skid_valid_q) && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                case ({main_valid_q, skid_valid_q})
                    2'b00: begin
                        if (push) begin
                            main_valid_d  = 1'b1;
                            main_data_d   = in_data_i;
                            main_commit_d = in_commit_i;
                        end
                    end
                    2'b10: begin
                        if (push && pop) begin
                            main_data_d   = in_data_i;
                            main_commit_d = in_commit_i;
                        end else if (push && SKID_EN) begin
                            skid_valid_d  = 1'b1;
                            skid_data_d   = in_data_i;
                            skid_commit_d = in_commit_i;
                        end else if (pop) begin
                            main_valid_d  = 1'b0;
                            main_data_d   = NOP_VALUE;
                            main_commit_d = 1'b0;
                        end
                    end
                    2'b11: begin
                        if (pop) begin
                            main_data_d   = skid_data_q;
                            main_commit_d = skid_commit_q;
                            skid_valid_d  = 1'b0;
                            skid_data_d   = NOP_VALUE;
                            skid_commit_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end

        occ_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_valid_q  <= 1'b0;
            main_data_q   <= NOP_VALUE;
            main_commit_q <= 1'b0;
            skid_valid_q  <= 1'b0;
            skid_data_q   <= NOP_VALUE;
            skid_commit_q <= 1'b0;
            occ_q         <= 2'd0;
            cnt_q         <= '0;
        end else begin
            main_valid_q  <= main_valid_d;
            main_data_q   <= main_data_d;
            main_commit_q <= main_commit_d;
            skid_valid_q  <= skid_valid_d;
            skid_data_q   <= skid_data_d;
            skid_commit_q <= skid_commit_d;
            occ_q         <= occ_d;
            cnt_q         <= cnt_d;
        end
    end

    // Skid may only hold a beat while main is also full.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(skid_valid_q && !main_valid_q));

endmodule

// File: doc/seg_pipe_stage.md
Name: seg_pipe_stage

Overview:
Parametrised successor to the fixed-field pipeline segment register. It is a generic inter-stage register with a valid/ready handshake, an optional skid entry that registers the ready path, and synchronous flush that inserts a configurable bubble. Flush drops are counted for performance monitoring. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries a packed payload plus the commit bit.

Parameters:
DATA_W, 32, payload width in bits (1..1024)
NOP_VALUE, {DATA_W{1'b0}}, payload driven during reset, after flush, and whenever out_valid=0
SKID_EN, 1, 1 = two-entry stage with fully registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 16, width of flush_drop_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
en  in  1  global stage enable; 0 freezes all state and blocks both handshakes
flush  in  1  synchronous flush request, honoured only when en=1
in_valid  in  1  upstream holds a valid payload
in_ready  out  1  stage accepts this cycle
in_data  in  DATA_W  upstream payload
in_commit  in  1  commit flag accompanying in_data
out_valid  out  1  stage presents a valid payload
out_ready  in  1  downstream accepts this cycle
out_data  out  DATA_W  payload; NOP_VALUE when out_valid=0
out_commit  out  1  main_commit AND out_valid
occupancy  out  2  number of valid entries (0..2; max 1 when SKID_EN=0)
flush_drop_cnt  out  CNT_W  saturating count of flush cycles that discarded at least one valid entry

Behaviour:
- Reset (rst=0, asynchronous):
  - main and skid entries are invalid, their data is NOP_VALUE, and their commit bits are 0.
  - Outputs: occupancy=0, flush_drop_cnt=0, out_valid=0, out_data=NOP_VALUE, out_commit=0.
  - Reset release is synchronous to clk. Reset mid-transfer discards all entries.
- Handshake rules:
  - Push = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - out_valid = en & main_valid.
  - in_ready with SKID_EN=1: en & !skid_valid, registered with no combinational path from out_ready.
  - in_ready with SKID_EN=0: en & (!main_valid | out_ready).
- en=0: in_ready=0 and out_valid=0; every register holds; flush is ignored. This matches the hold-on-disable semantics of the existing segment register.
- flush=1 with en=1:
  - Highest priority over push and pop in the same cycle. A push or pop is not performed; in_ready and out_valid remain as computed, but the upstream or downstream beat is lost by design.
  - Both entries become invalid with data NOP_VALUE and commit 0.
  - flush_drop_cnt increments by 1 if main_valid|skid_valid, and saturates at all-ones.
- Entry transitions, en=1 and flush=0 (state = main_valid, skid_valid):
  - (0,0) + push → main loads; next state (1,0).
  - (1,0) + push + pop → main loads the new beat; stays (1,0).
  - (1,0) + push, no pop → skid loads; next state (1,1). SKID_EN=1 only.
  - (1,0) + pop, no push → main invalid; next state (0,0).
  - (1,1) + pop → main ← skid, skid invalid; next state (1,0). No push is possible because in_ready=0.
  - (1,1), no pop → hold.
  - (0,1) is illegal and unreachable; assertion in verification.
- Ordering is strictly FIFO. Latency is 1 cycle from push to out_valid. Sustained throughput is 1 beat per cycle with out_ready=1.
- Stall is expressed by out_ready=0. A held main entry keeps out_data stable until popped; data must never change while out_valid=1 and out_ready=0.
- out_data is driven from registers only (mux between main data and NOP_VALUE gated by out_valid).
- occupancy = main_valid + skid_valid, registered.

Test Plan:
- Reset and defaults: NOP_VALUE=32'h0, apply rst=0 mid-stream with 2 entries held → out_valid=0, out_data=0, occupancy=0, flush_drop_cnt=0 immediately, without waiting for a clk edge.
- Streaming: en=1, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles → out_data 0x11,0x22,0x33 one cycle later each; in_ready stays 1; occupancy stays 1.
- Backpressure/skid (SKID_EN=1): push 0xA, then 0xB while out_ready=0 → occupancy=2, in_ready=0. Raise out_ready → pops 0xA then 0xB in order; in_ready returns to 1 the cycle after the first pop.
- Flush priority: occupancy=2, flush=1 with in_valid=1 and out_ready=1 in the same cycle → next cycle occupancy=0, out_data=NOP_VALUE, flush_drop_cnt=1. A second flush while empty leaves the counter at 1.
- Enable freeze: hold en=0 for 5 cycles with in_valid=1, out_ready=1, flush=1 → in_ready=0, out_valid=0, entries and counter unchanged. Restoring en=1 resumes with the original data.
- SKID_EN=0, CNT_W=2: with main full, out_ready=1 and in_valid=1 → same-cycle in_ready=1 and replace. Four flushes of a full stage → counter saturates at 3.
